// File: rtl/cardinal_nic.sv
// cardinal_nic: processor-side network interface for one cardinal router node.
// Provides a one-entry output buffer injected into the router under phase gating,
// a one-entry input buffer filled by router ejection, and wrapping tx/rx counters.
module cardinal_nic #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned VC_BIT = 63,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    output logic              net_so,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_ro,
    input  logic              net_polarity,
    input  logic              net_si,
    input  logic [DATA_W-1:0] net_di,
    output logic              net_ri
);

    logic              out_full_q, out_full_d;
    logic              in_full_q, in_full_d;
    logic [DATA_W-1:0] out_buf_q, out_buf_d;
    logic [DATA_W-1:0] in_buf_q, in_buf_d;
    logic [CNT_W-1:0]  tx_count_q, tx_count_d;
    logic [CNT_W-1:0]  rx_count_q, rx_count_d;
    logic [DATA_W-1:0] d_out_q, d_out_d;
    logic              net_so_q, net_so_d;
    logic [DATA_W-1:0] net_do_q, net_do_d;

    logic inject;
    logic rd_en;
    logic wr_en;

    assign rd_en  = nicEn & ~nicWrEn;
    assign wr_en  = nicEn & nicWrEn;
    // The router only accepts the VC it is not draining in the current phase.
    assign inject = out_full_q & net_ro & (out_buf_q[VC_BIT] != net_polarity);

    assign d_out  = d_out_q;
    assign net_so = net_so_q;
    assign net_do = net_do_q;
    assign net_ri = ~in_full_q;

    // Next-state for buffers, counters, injection and processor read data.
    always_comb begin
        out_full_d = out_full_q;
        in_full_d  = in_full_q;
        out_buf_d  = out_buf_q;
        in_buf_d   = in_buf_q;
        tx_count_d = tx_count_q;
        rx_count_d = rx_count_q;
        d_out_d    = d_out_q;
        net_so_d   = 1'b0;
        net_do_d   = net_do_q;

        // Inject and accept-write are exclusive: a write only lands when the
        // buffer was already empty before this edge, so a drain-cycle write drops.
        if (inject) begin
            net_so_d   = 1'b1;
            net_do_d   = out_buf_q;
            out_full_d = 1'b0;
            tx_count_d = tx_count_q + CNT_W'(1);
        end else if (wr_en && addr == 3'b010 && !out_full_q) begin
            out_buf_d  = d_in;
            out_full_d = 1'b1;
        end

        // Capture only when ready was already high; a same-cycle read that
        // empties the buffer does not open it until the next edge.
        if (net_si && !in_full_q) begin
            in_buf_d   = net_di;
            in_full_d  = 1'b1;
            rx_count_d = rx_count_q + CNT_W'(1);
        end

        if (rd_en) begin
            case (addr)
                3'b000: begin
                    d_out_d = in_buf_q;
                    if (in_full_q) begin
                        in_full_d = 1'b0;
                    end
                end
                3'b001:  d_out_d = {{(DATA_W-1){1'b0}}, in_full_q};
                3'b011:  d_out_d = {{(DATA_W-1){1'b0}}, out_full_q};
                3'b100:  d_out_d = DATA_W'(tx_count_q);
                3'b101:  d_out_d = DATA_W'(rx_count_q);
                default: d_out_d = '0;
            endcase
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_full_q <= 1'b0;
            in_full_q  <= 1'b0;
            out_buf_q  <= '0;
            in_buf_q   <= '0;
            tx_count_q <= '0;
            rx_count_q <= '0;
            d_out_q    <= '0;
            net_so_q   <= 1'b0;
            net_do_q   <= '0;
        end else begin
            out_full_q <= out_full_d;
            in_full_q  <= in_full_d;
            out_buf_q  <= out_buf_d;
            in_buf_q   <= in_buf_d;
            tx_count_q <= tx_count_d;
            rx_count_q <= rx_count_d;
            d_out_q    <= d_out_d;
            net_so_q   <= net_so_d;
            net_do_q   <= net_do_d;
        end
    end

endmodule
